// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: bus-wait stalls with timeout, branch redirect
// flushes and load-use bubble insertion, plus a saturating stall counter.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        pc_stall_o,
  output logic        pc_load_o,
  output logic [31:0] pc_target_o,
  output logic        if_id_stall_o,
  output logic        id_ex_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_stall_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned WCNT_W = 8;
  localparam int unsigned CNT_W  = 32;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] BUS_WAIT = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              bus_err_nxt;
  logic              load_use_c;

  // Load-use: a load in ex writes a register the id instruction reads.
  always_comb begin
    load_use_c = 1'b0;
    if (ex_load_i && (ex_rd_addr_i != 5'd0)) begin
      load_use_c = (id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                   (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wcnt      <= '0;
      bus_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      bus_err_o <= bus_err_nxt;
    end
  end

  // Next state and pipeline controls; priority is bus wait > jump > load-use.
  always_comb begin
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    bus_err_nxt   = bus_err_o;
    pc_stall_o    = 1'b0;
    pc_load_o     = 1'b0;
    pc_target_o   = '0;
    if_id_stall_o = 1'b0;
    id_ex_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    ex_stall_o    = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_req_i && !mem_ack_i) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            ex_stall_o    = 1'b1;
            state_nxt     = BUS_WAIT;
            wcnt_nxt      = WCNT_W'(1);
          end else if (jump_en_i) begin
            pc_load_o     = 1'b1;
            pc_target_o   = jump_addr_i;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (load_use_c) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end
        end
        BUS_WAIT: begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          ex_stall_o    = 1'b1;
          if (mem_ack_i) begin
            state_nxt = RUN;
            wcnt_nxt  = '0;
          end else if (wcnt == WCNT_W'(TIMEOUT)) begin
            // Give up on the access; the error stays flagged until reset.
            bus_err_nxt = 1'b1;
            state_nxt   = RUN;
            wcnt_nxt    = '0;
          end else begin
            wcnt_nxt = wcnt + WCNT_W'(1);
          end
        end
        default: begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (pc_stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (TIMEOUT=4).
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_load_i;
  logic [4:0]  ex_rd_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        pc_stall_o;
  logic        pc_load_o;
  logic [31:0] pc_target_o;
  logic        if_id_stall_o;
  logic        id_ex_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        ex_stall_o;
  logic        bus_err_o;
  logic [31:0] stall_cnt_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pipe_ctrl #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .ex_load_i     (ex_load_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .mem_req_i     (mem_req_i),
    .mem_ack_i     (mem_ack_i),
    .pc_stall_o    (pc_stall_o),
    .pc_load_o     (pc_load_o),
    .pc_target_o   (pc_target_o),
    .if_id_stall_o (if_id_stall_o),
    .id_ex_stall_o (id_ex_stall_o),
    .if_id_flush_o (if_id_flush_o),
    .id_ex_flush_o (id_ex_flush_o),
    .ex_stall_o    (ex_stall_o),
    .bus_err_o     (bus_err_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Packed control vector: {pc_stall, pc_load, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_stall}
  function automatic logic [31:0] ctl();
    return 32'({pc_stall_o, pc_load_o, if_id_stall_o, id_ex_stall_o,
                if_id_flush_o, id_ex_flush_o, ex_stall_o});
  endfunction

  localparam logic [31:0] C_NONE  = 32'b000_0000;
  localparam logic [31:0] C_JUMP  = 32'b010_0110;
  localparam logic [31:0] C_LU    = 32'b101_0010;
  localparam logic [31:0] C_BUS   = 32'b101_1001;

  // Inputs change 1ns after the rising edge; checks happen 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    jump_en_i = 0; jump_addr_i = '0; ex_load_i = 0; ex_rd_addr_i = '0;
    id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rs1_used_i = 0; id_rs2_used_i = 0;
    mem_req_i = 0; mem_ack_i = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    // Combinational outputs stay quiet under reset even with requests present.
    jump_en_i = 1; jump_addr_i = 32'h44; mem_req_i = 1;
    #1;
    chk("rst_ctl", ctl(), C_NONE);
    chk("rst_target", pc_target_o, 32'h0);
    step();
    idle(); rst = 0;
    #1;
    chk("reset_ctl", ctl(), C_NONE);
    chk("reset_cnt", stall_cnt_o, 32'd0);
    chk("reset_err", 32'(bus_err_o), 32'd0);

    // Jump redirect in RUN
    jump_en_i = 1; jump_addr_i = 32'h0000_0080;
    #1;
    chk("jump_ctl", ctl(), C_JUMP);
    chk("jump_target", pc_target_o, 32'h80);
    step();
    idle();
    #1;
    chk("jump_cnt", stall_cnt_o, 32'd0);
    chk("nojump_target", pc_target_o, 32'h0);

    // Load-use on rs2: one bubble
    ex_load_i = 1; ex_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs2_used_i = 1;
    #1;
    chk("lu_rs2_ctl", ctl(), C_LU);
    step();
    idle();
    #1;
    chk("lu_after_ctl", ctl(), C_NONE);
    chk("lu_cnt", stall_cnt_o, 32'd1);

    // Load-use on rs1
    ex_load_i = 1; ex_rd_addr_i = 5'd9; id_rs1_addr_i = 5'd9; id_rs1_used_i = 1;
    #1;
    chk("lu_rs1_ctl", ctl(), C_LU);
    step();
    // Match but source unused
    id_rs1_used_i = 0;
    #1;
    chk("lu_unused_ctl", ctl(), C_NONE);
    // rd = x0 never hazards
    ex_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_rs2_used_i = 1;
    id_rs1_addr_i = 5'd0; id_rs1_used_i = 1;
    #1;
    chk("lu_x0_ctl", ctl(), C_NONE);
    step();
    chk("lu_x0_cnt", stall_cnt_o, 32'd2);

    // Jump and load-use together: jump wins
    idle();
    jump_en_i = 1; jump_addr_i = 32'h0000_0200;
    ex_load_i = 1; ex_rd_addr_i = 5'd7; id_rs1_addr_i = 5'd7; id_rs1_used_i = 1;
    #1;
    chk("prio_ctl", ctl(), C_JUMP);
    chk("prio_target", pc_target_o, 32'h200);
    step();
    idle();
    #1;
    chk("prio_cnt", stall_cnt_o, 32'd2);

    // Immediate ack: no stall
    mem_req_i = 1; mem_ack_i = 1;
    #1;
    chk("fastack_ctl", ctl(), C_NONE);
    step();
    idle();
    #1;
    chk("fastack_cnt", stall_cnt_o, 32'd2);

    // Ack three cycles after request: four stalled cycles
    mem_req_i = 1;
    #1;
    chk("bw0_ctl", ctl(), C_BUS);
    step();
    jump_en_i = 1; jump_addr_i = 32'h300;
    #1;
    chk("bw1_jump_ignored", ctl(), C_BUS);
    chk("bw1_target", pc_target_o, 32'h0);
    step();
    jump_en_i = 0;
    ex_load_i = 1; ex_rd_addr_i = 5'd3; id_rs1_addr_i = 5'd3; id_rs1_used_i = 1;
    #1;
    chk("bw2_ctl", ctl(), C_BUS);
    step();
    idle(); mem_req_i = 1; mem_ack_i = 1;
    #1;
    chk("bw3_ack_ctl", ctl(), C_BUS);
    step();
    idle();
    #1;
    chk("bw_done_ctl", ctl(), C_NONE);
    chk("bw_cnt", stall_cnt_o, 32'd6);
    chk("bw_err", 32'(bus_err_o), 32'd0);
    jump_en_i = 1; jump_addr_i = 32'h40;
    #1;
    chk("bw_run_jump", ctl(), C_JUMP);
    step();
    idle();

    // Timeout: request entry cycle plus four wait cycles
    mem_req_i = 1;
    #1;
    chk("to0_ctl", ctl(), C_BUS);
    step();
    idle();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("to%0d_ctl", i), ctl(), C_BUS);
      chk($sformatf("to%0d_err", i), 32'(bus_err_o), 32'd0);
      step();
    end
    #1;
    chk("to_done_ctl", ctl(), C_NONE);
    chk("to_err", 32'(bus_err_o), 32'd1);
    chk("to_cnt", stall_cnt_o, 32'd11);
    for (int i = 0; i < 3; i++) step();
    chk("to_err_sticky", 32'(bus_err_o), 32'd1);

    // Reset in the middle of a bus wait
    mem_req_i = 1;
    step();
    idle();
    step(); step();
    #1;
    chk("rbw_ctl", ctl(), C_BUS);
    rst = 1;
    #1;
    chk("rbw_rst_ctl", ctl(), C_NONE);
    step();
    rst = 0;
    #1;
    chk("rbw_after_ctl", ctl(), C_NONE);
    chk("rbw_cnt", stall_cnt_o, 32'd0);
    chk("rbw_err", 32'(bus_err_o), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("rbw_err_later", 32'(bus_err_o), 32'd0);
    chk("rbw_cnt_later", stall_cnt_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
